// File: rtl/calc_pkg.sv
// Shared types and default sizing for the parametrised MAC array.
// Imported by the interface, the row datapath and the top.
package calc_pkg;

    localparam int DEF_ROWS      = 8;
    localparam int DEF_COLS      = 4;
    localparam int DEF_DW        = 16;
    localparam int DEF_SW        = 5;
    localparam int DEF_OW        = 17;
    localparam int DEF_MAX_BEATS = 64;

    // Cycles spent in DRAIN so that out_valid lands 3 edges after the last beat
    // (or after start when the job has no beats).
    localparam logic [1:0] DRAIN_CYCLES = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_e;

    typedef enum logic {
        MODE_ZERO,
        MODE_BIAS
    } mode_e;

endpackage

// File: rtl/calc_mac_array_if.sv
// Beat input and result output handshakes of the MAC array.
// master = beat producer / result consumer, slave = the array.
interface calc_mac_array_if
    import calc_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int DW   = DEF_DW,
    parameter int SW   = DEF_SW,
    parameter int OW   = DEF_OW
);
    logic                      in_valid;
    logic                      in_ready;
    logic [ROWS*COLS*DW-1:0]   a_tile;
    logic [COLS*SW-1:0]        s_vec;
    logic                      out_valid;
    logic                      out_ready;
    logic [ROWS*OW-1:0]        result_out;

    modport master (
        output in_valid, a_tile, s_vec, out_ready,
        input  in_ready, out_valid, result_out
    );

    modport slave (
        input  in_valid, a_tile, s_vec, out_ready,
        output in_ready, out_valid, result_out
    );
endinterface

// File: rtl/calc_dot_row.sv
// One output row: COLS signed multipliers (stage 1) feeding an adder tree
// into a wrapping OW-bit accumulator (stage 2).
module calc_dot_row
    import calc_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int DW   = DEF_DW,
    parameter int SW   = DEF_SW,
    parameter int OW   = DEF_OW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_en,
    input  logic [OW-1:0]        init_val,
    input  logic                 st1_en,
    input  logic                 st2_en,
    input  logic [COLS*DW-1:0]   a_row,
    input  logic [COLS*SW-1:0]   s_vec,
    output logic [OW-1:0]        acc
);
    localparam int PW = DW + SW + 1;
    // Bits of a product above OW can never reach the wrapping accumulator,
    // so each product is formed and held at min(PW, OW) bits.
    localparam int MW = (PW < OW) ? PW : OW;

    logic signed [MW-1:0] prod_next [COLS];
    logic signed [MW-1:0] prod_reg  [COLS];
    logic        [OW-1:0] sum_next;
    logic        [OW-1:0] acc_reg;

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            logic signed [MW-1:0] a_ext;
            logic signed [MW-1:0] s_ext;
            assign a_ext         = MW'({1'b0, a_row[gi*DW +: DW]});
            assign s_ext         = MW'($signed(s_vec[gi*SW +: SW]));
            assign prod_next[gi] = a_ext * s_ext;
        end
    endgenerate

    always_comb begin
        sum_next = '0;
        for (int c = 0; c < COLS; c++) begin
            sum_next = sum_next + OW'(prod_reg[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < COLS; c++) begin
                prod_reg[c] <= '0;
            end
            acc_reg <= '0;
        end else begin
            if (st1_en) begin
                for (int c = 0; c < COLS; c++) begin
                    prod_reg[c] <= prod_next[c];
                end
            end
            if (init_en) begin
                acc_reg <= init_val;
            end else if (st2_en) begin
                acc_reg <= acc_reg + sum_next;
            end
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/calc_mac_array.sv
// Y = A*S (+E) over a multi-beat job: job FSM, beat counter and handshakes,
// with ROWS independent calc_dot_row lanes doing the arithmetic.
module calc_mac_array
    import calc_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int DW        = DEF_DW,
    parameter int SW        = DEF_SW,
    parameter int OW        = DEF_OW,
    parameter int MAX_BEATS = DEF_MAX_BEATS,
    parameter int BW        = $clog2(MAX_BEATS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode_cfg,
    input  logic [BW-1:0]       beats_cfg,
    input  logic [ROWS*OW-1:0]  bias_in,
    output logic                busy,
    calc_mac_array_if.slave     bus
);
    state_e              state_reg;
    logic [BW-1:0]       beat_cnt_reg;
    logic [1:0]          drain_cnt_reg;
    logic                st1_valid_reg;
    logic                st2_valid_reg;
    logic                out_valid_reg;
    logic [ROWS*OW-1:0]  result_reg;
    logic [ROWS*OW-1:0]  acc_flat;

    logic beat_fire;
    logic init_en;
    logic use_bias;
    logic pipe_empty;

    assign beat_fire  = bus.in_valid && (state_reg == LOAD);
    assign init_en    = start && (state_reg == IDLE);
    assign use_bias   = (mode_e'(mode_cfg) == MODE_BIAS);
    assign pipe_empty = (drain_cnt_reg == 2'd0) && !st1_valid_reg && !st2_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            logic [OW-1:0] init_val;
            assign init_val = use_bias ? bias_in[gi*OW +: OW] : '0;

            calc_dot_row #(
                .COLS (COLS),
                .DW   (DW),
                .SW   (SW),
                .OW   (OW)
            ) u_row (
                .clk      (clk),
                .rst_n    (rst_n),
                .init_en  (init_en),
                .init_val (init_val),
                .st1_en   (beat_fire),
                .st2_en   (st1_valid_reg),
                .a_row    (bus.a_tile[gi*COLS*DW +: COLS*DW]),
                .s_vec    (bus.s_vec),
                .acc      (acc_flat[gi*OW +: OW])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            beat_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
            st1_valid_reg <= 1'b0;
            st2_valid_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
        end else begin
            st1_valid_reg <= beat_fire;
            st2_valid_reg <= st1_valid_reg;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        beat_cnt_reg  <= beats_cfg;
                        drain_cnt_reg <= DRAIN_CYCLES;
                        state_reg     <= (beats_cfg == '0) ? DRAIN : LOAD;
                    end
                end
                LOAD: begin
                    if (beat_fire) begin
                        beat_cnt_reg <= beat_cnt_reg - BW'(1);
                        if (beat_cnt_reg == BW'(1)) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The result is captured only here so it stays frozen through DONE and after.
                    if (pipe_empty) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        result_reg    <= acc_flat;
                    end else if (drain_cnt_reg != 2'd0) begin
                        drain_cnt_reg <= drain_cnt_reg - 2'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state_reg == LOAD);
    assign bus.out_valid  = out_valid_reg;
    assign bus.result_out = result_reg;
    assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_calc_mac_array.sv
// Directed bench for calc_mac_array: per-scenario tasks with hand-computed results.
module tb_calc_mac_array;
    localparam int ROWS      = 8;
    localparam int COLS      = 4;
    localparam int DW        = 16;
    localparam int SW        = 5;
    localparam int OW        = 17;
    localparam int MAX_BEATS = 64;
    localparam int BW        = $clog2(MAX_BEATS + 1);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               mode_cfg;
    logic [BW-1:0]      beats_cfg;
    logic [ROWS*OW-1:0] bias_in;
    logic               busy;

    int errors = 0;
    int checks = 0;

    calc_mac_array_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .SW(SW), .OW(OW)) bus ();

    calc_mac_array #(
        .ROWS(ROWS), .COLS(COLS), .DW(DW), .SW(SW), .OW(OW), .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode_cfg  (mode_cfg),
        .beats_cfg (beats_cfg),
        .bias_in   (bias_in),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic start_job(input logic mode, input int beats, input logic [ROWS*OW-1:0] bias);
        @(negedge clk);
        start     = 1'b1;
        mode_cfg  = mode;
        beats_cfg = BW'(beats);
        bias_in   = bias;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic drive_beat(input logic [ROWS*COLS*DW-1:0] a, input logic [COLS*SW-1:0] s,
                              input int gap);
        bus.in_valid = 1'b1;
        bus.a_tile   = a;
        bus.s_vec    = s;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_out(output int cycles);
        cycles = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [ROWS*COLS*DW-1:0] fill_a(input logic [DW-1:0] v);
        logic [ROWS*COLS*DW-1:0] a;
        for (int i = 0; i < ROWS*COLS; i++) a[i*DW +: DW] = v;
        return a;
    endfunction

    function automatic logic [COLS*SW-1:0] fill_s(input logic [SW-1:0] v);
        logic [COLS*SW-1:0] s;
        for (int c = 0; c < COLS; c++) s[c*SW +: SW] = v;
        return s;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.result_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b busy=%b result=%h required all 0",
                     bus.in_ready, bus.out_valid, busy, bus.result_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b in_ready=%b required 0 0", busy, bus.in_ready);
        end
        $display("txn reset: busy=%b out_valid=%b", busy, bus.out_valid);
    endtask

    task automatic test_single_beat();
        int cyc;
        logic [OW-1:0] got;
        start_job(1'b0, 1, '0);
        checks++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_load_state: busy=%b in_ready=%b required 1 1", busy, bus.in_ready);
        end
        drive_beat(fill_a(DW'(1)), fill_s(SW'(1)), 0);
        wait_out(cyc);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles required 3", cyc);
        end
        for (int r = 0; r < ROWS; r++) begin
            got = bus.result_out[r*OW +: OW];
            checks++;
            if (got !== OW'(4)) begin
                errors++;
                $display("FAIL single_y%0d: got %0d required 4", r, got);
            end
        end
        $display("txn single_beat: cycles=%0d y0=%0d", cyc, bus.result_out[0 +: OW]);
        consume();
        got = bus.result_out[0 +: OW];
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || got !== OW'(4)) begin
            errors++;
            $display("FAIL single_handshake_hold: out_valid=%b busy=%b y0=%0d required 0 0 4",
                     bus.out_valid, busy, got);
        end
    endtask

    task automatic test_bias_back_to_back();
        int cyc;
        int sv[COLS] = '{1, -1, 2, -2};
        logic [ROWS*OW-1:0]      bias;
        logic [ROWS*COLS*DW-1:0] a;
        logic [COLS*SW-1:0]      s;
        logic [OW-1:0]           got, expv;
        int                      e;
        for (int r = 0; r < ROWS; r++) begin
            bias[r*OW +: OW] = OW'(r);
            for (int c = 0; c < COLS; c++) a[(r*COLS+c)*DW +: DW] = DW'(r + c);
        end
        for (int c = 0; c < COLS; c++) s[c*SW +: SW] = sv[c][SW-1:0];
        start_job(1'b1, 4, bias);
        for (int b = 0; b < 4; b++) drive_beat(a, s, 0);
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain_state: in_ready=%b busy=%b required 0 1", bus.in_ready, busy);
        end
        wait_out(cyc);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL b2b_latency: got %0d cycles required 3", cyc);
        end
        for (int r = 0; r < ROWS; r++) begin
            e    = r - 12;
            expv = e[OW-1:0];
            got  = bus.result_out[r*OW +: OW];
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL b2b_y%0d: got %h required %h", r, got, expv);
            end
        end
        $display("txn bias_b2b: cycles=%0d y0=%h y7=%h", cyc, bus.result_out[0 +: OW], bus.result_out[7*OW +: OW]);
        consume();
    endtask

    task automatic test_wrap();
        int            cyc;
        longint        model = 0;
        logic [OW-1:0] expv, got;
        start_job(1'b0, 64, '0);
        for (int b = 0; b < 64; b++) begin
            drive_beat(fill_a(16'hFFFF), fill_s(5'h10), 0);
            for (int c = 0; c < COLS; c++) model = model + 65535 * -16;
        end
        expv = model[OW-1:0];
        wait_out(cyc);
        checks++;
        if (cyc != 3 || $isunknown(bus.result_out)) begin
            errors++;
            $display("FAIL wrap_latency_x: cycles=%0d xbits=%b required 3 and no X", cyc, $isunknown(bus.result_out));
        end
        for (int r = 0; r < ROWS; r++) begin
            got = bus.result_out[r*OW +: OW];
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL wrap_y%0d: got %h required %h", r, got, expv);
            end
        end
        $display("txn wrap64: cycles=%0d y0=%h", cyc, bus.result_out[0 +: OW]);
        consume();
    endtask

    task automatic test_zero_beats();
        int                 cyc = -1;
        logic               ready_seen = 1'b0;
        logic [ROWS*OW-1:0] bias;
        logic [OW-1:0]      got;
        for (int r = 0; r < ROWS; r++) bias[r*OW +: OW] = OW'(5);
        start_job(1'b1, 0, bias);
        if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
            if (bus.out_valid === 1'b1) begin
                cyc = k;
                break;
            end
        end
        checks++;
        if (ready_seen) begin
            errors++;
            $display("FAIL zero_in_ready: in_ready went 1 required 0 throughout");
        end
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL zero_latency: got %0d cycles required 3", cyc);
        end
        for (int r = 0; r < ROWS; r++) begin
            got = bus.result_out[r*OW +: OW];
            checks++;
            if (got !== OW'(5)) begin
                errors++;
                $display("FAIL zero_y%0d: got %0d required 5", r, got);
            end
        end
        $display("txn zero_beats: cycles=%0d y0=%0d", cyc, bus.result_out[0 +: OW]);
        consume();
    endtask

    task automatic test_gaps_stall();
        int                 cyc;
        logic               unstable = 1'b0;
        logic [ROWS*OW-1:0] ones;
        logic [OW-1:0]      got;
        for (int r = 0; r < ROWS; r++) ones[r*OW +: OW] = '1;
        start_job(1'b0, 3, '0);
        drive_beat(fill_a(DW'(1)), fill_s(SW'(1)), 1);
        // start during LOAD must not restart the job
        start = 1'b1; mode_cfg = 1'b1; beats_cfg = BW'(7); bias_in = ones;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL gaps_stall_ready: in_ready=%b required 1 during stall", bus.in_ready);
        end
        drive_beat(fill_a(DW'(2)), fill_s(SW'(1)), 3);
        drive_beat(fill_a(DW'(3)), fill_s(SW'(1)), 0);
        wait_out(cyc);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL gaps_latency: got %0d cycles required 3", cyc);
        end
        for (int r = 0; r < ROWS; r++) begin
            got = bus.result_out[r*OW +: OW];
            checks++;
            if (got !== OW'(24)) begin
                errors++;
                $display("FAIL gaps_y%0d: got %0d required 24", r, got);
            end
        end
        $display("txn gaps: cycles=%0d y0=%0d", cyc, bus.result_out[0 +: OW]);
        for (int k = 0; k < 10; k++) begin
            start = (k == 4);
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.result_out[3*OW +: OW] !== OW'(24)) unstable = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (unstable || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_stable: unstable=%b busy=%b required 0 1", unstable, busy);
        end
        // start coincident with the DONE handshake is ignored
        start = 1'b1; mode_cfg = 1'b1; beats_cfg = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        got = bus.result_out[0 +: OW];
        checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || got !== OW'(24)) begin
            errors++;
            $display("FAIL done_start_ignored: busy=%b out_valid=%b y0=%0d required 0 0 24",
                     busy, bus.out_valid, got);
        end
        $display("txn hold_and_handshake: busy=%b y0=%0d", busy, got);
    endtask

    task automatic test_midjob_reset();
        int            cyc;
        logic [OW-1:0] got;
        start_job(1'b0, 4, '0);
        drive_beat(fill_a(DW'(7)), fill_s(SW'(3)), 0);
        drive_beat(fill_a(DW'(7)), fill_s(SW'(3)), 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.result_out !== '0) begin
            errors++;
            $display("FAIL midjob_reset: in_ready=%b out_valid=%b busy=%b result=%h required all 0",
                     bus.in_ready, bus.out_valid, busy, bus.result_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_job(1'b0, 1, '0);
        drive_beat(fill_a(DW'(1)), fill_s(SW'(2)), 0);
        wait_out(cyc);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL post_reset_latency: got %0d cycles required 3", cyc);
        end
        for (int r = 0; r < ROWS; r++) begin
            got = bus.result_out[r*OW +: OW];
            checks++;
            if (got !== OW'(8)) begin
                errors++;
                $display("FAIL post_reset_y%0d: got %0d required 8", r, got);
            end
        end
        $display("txn post_reset_job: cycles=%0d y0=%0d", cyc, bus.result_out[0 +: OW]);
        consume();
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        mode_cfg      = 1'b0;
        beats_cfg     = '0;
        bias_in       = '0;
        bus.in_valid  = 1'b0;
        bus.a_tile    = '0;
        bus.s_vec     = '0;
        bus.out_ready = 1'b0;

        test_reset();
        test_single_beat();
        test_bias_back_to_back();
        test_wrap();
        test_zero_beats();
        test_gaps_stall();
        test_midjob_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
